alu_op_sequencer: RTL and testbench

//   Shares one 8-bit ALU result mux between two requesters (A=0, B=1). Accepts opcode+operand

---
 rtl/alu_op_sequencer_if.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-side signals of the op sequencer, bundled so the
// issue logic, the sequencer and the ALU datapath share one connection.
interface alu_op_sequencer_if #(
   parameter int DW = 8
);
   logic          a_req_valid;
   logic          a_req_ready;
   logic [3:0]    a_req_op;
   logic [DW-1:0] a_req_x;
   logic [DW-1:0] a_req_y;

   logic          b_req_valid;
   logic          b_req_ready;
   logic [3:0]    b_req_op;
   logic [DW-1:0] b_req_x;
   logic [DW-1:0] b_req_y;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_id;
   logic          rsp_err;

   logic [DW-1:0] alu_x;
   logic [DW-1:0] alu_y;
   logic [3:0]    alu_sel;
   logic [DW-1:0] alu_result;

   logic          busy;

   modport slave (
      input  a_req_valid, a_req_op, a_req_x, a_req_y,
      output a_req_ready,
      input  b_req_valid, b_req_op, b_req_x, b_req_y,
      output b_req_ready,
      output rsp_valid, rsp_data, rsp_id, rsp_err,
      input  rsp_ready,
      output alu_x, alu_y, alu_sel,
      input  alu_result,
      output busy
   );

   modport master (
      output a_req_valid, a_req_op, a_req_x, a_req_y,
      input  a_req_ready,
      output b_req_valid, b_req_op, b_req_x, b_req_y,
      input  b_req_ready,
      input  rsp_valid, rsp_data, rsp_id, rsp_err,
      output rsp_ready,
      input  alu_x, alu_y, alu_sel,
      output alu_result,
      input  busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Round-robin sequencer sharing one ALU result mux between requesters A and B:
// maps opcodes to sparse select codes, holds operands for ALU_LAT cycles, returns the result.
module alu_op_sequencer #(
   parameter int DW      = 8,
   parameter int ALU_LAT = 1
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_q, last_d;
   logic [3:0]    alu_sel_q, alu_sel_d;
   logic [DW-1:0] alu_x_q, alu_x_d;
   logic [DW-1:0] alu_y_q, alu_y_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          rsp_id_q, rsp_id_d;
   logic          rsp_err_q, rsp_err_d;

   logic          grant_a;
   logic          grant_b;
   logic          req_fire;
   logic          req_id;
   logic [3:0]    req_op;
   logic [DW-1:0] req_x;
   logic [DW-1:0] req_y;
   logic          op_legal;
   logic [3:0]    op_code;

   function automatic logic [3:0] map_op(input logic [3:0] op);
      logic [3:0] code;
      case (op)
         4'd0:    code = 4'b0000;
         4'd1:    code = 4'b0001;
         4'd2:    code = 4'b0011;
         4'd3:    code = 4'b1000;
         4'd4:    code = 4'b1001;
         4'd5:    code = 4'b1010;
         4'd6:    code = 4'b1011;
         4'd7:    code = 4'b1100;
         4'd8:    code = 4'b1101;
         4'd9:    code = 4'b1110;
         4'd10:   code = 4'b1111;
         default: code = 4'b0000;
      endcase
      return code;
   endfunction

   // last_q remembers who won the previous handshake; on a tie the other side wins.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == IDLE) begin
         grant_a = bus.a_req_valid & (~bus.b_req_valid | last_q);
         grant_b = bus.b_req_valid & (~bus.a_req_valid | ~last_q);
      end
      req_fire = grant_a | grant_b;
      req_id   = grant_b;
      req_op   = grant_b ? bus.b_req_op : bus.a_req_op;
      req_x    = grant_b ? bus.b_req_x  : bus.a_req_x;
      req_y    = grant_b ? bus.b_req_y  : bus.a_req_y;
      op_legal = (req_op <= 4'd10);
      op_code  = map_op(req_op);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      alu_sel_d  = alu_sel_q;
      alu_x_d    = alu_x_q;
      alu_y_d    = alu_y_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_err_d  = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (req_fire) begin
               last_d    = req_id;
               rsp_id_d  = req_id;
               rsp_err_d = ~op_legal;
               if (op_legal) begin
                  state_d   = EXEC;
                  cnt_d     = CNT_INIT;
                  alu_sel_d = op_code;
                  alu_x_d   = req_x;
                  alu_y_d   = req_y;
               end else begin
                  // Illegal opcodes never touch the ALU; operands keep their old values.
                  state_d    = RESP;
                  rsp_data_d = '0;
               end
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               rsp_data_d = bus.alu_result;
               alu_sel_d  = 4'b0000;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            alu_sel_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         last_q     <= 1'b1;
         alu_sel_q  <= 4'b0000;
         alu_x_q    <= '0;
         alu_y_q    <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         alu_sel_q  <= alu_sel_d;
         alu_x_q    <= alu_x_d;
         alu_y_q    <= alu_y_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign bus.a_req_ready = grant_a;
   assign bus.b_req_ready = grant_b;
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.alu_x       = alu_x_q;
   assign bus.alu_y       = alu_y_q;
   assign bus.alu_sel     = alu_sel_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_op_sequencer;

   localparam int DW  = 8;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.DW(DW)) bus3 ();
   alu_op_sequencer_if #(.DW(DW)) bus1 ();

   alu_op_sequencer #(.DW(DW), .ALU_LAT(LAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   alu_op_sequencer #(.DW(DW), .ALU_LAT(1)) u_dut_lat1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       id;
      logic [3:0] op;
      logic [7:0] x;
      logic [7:0] y;
      logic [3:0] exp_sel;
      logic [7:0] exp_data;
      logic       exp_err;
      logic [7:0] exp_x;
   } vec_t;

   vec_t       vecs [15];
   logic [3:0] sel_map [0:10];

   // Behavioural ALU behind the result mux; each select code gets a distinct function.
   function automatic logic [7:0] alu_fn(input logic [3:0] sel, input logic [7:0] x, input logic [7:0] y);
      case (sel)
         4'b0000: return x & y;
         4'b0001: return x | y;
         4'b0011: return x + y;
         4'b1000: return x - y;
         4'b1001: return x ^ y;
         4'b1010: return ~x;
         4'b1011: return x << 1;
         4'b1100: return x >> 1;
         4'b1101: return y - x;
         4'b1110: return x + 8'd1;
         4'b1111: return {x[3:0], y[3:0]};
         default: return 8'hEE;
      endcase
   endfunction

   assign bus3.alu_result = alu_fn(bus3.alu_sel, bus3.alu_x, bus3.alu_y);
   assign bus1.alu_result = alu_fn(bus1.alu_sel, bus1.alu_x, bus1.alu_y);

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%04b expected=%04b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%02h expected=0x%02h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus3.a_req_valid = 1'b0; bus3.a_req_op = 4'd0; bus3.a_req_x = 8'h00; bus3.a_req_y = 8'h00;
      bus3.b_req_valid = 1'b0; bus3.b_req_op = 4'd0; bus3.b_req_x = 8'h00; bus3.b_req_y = 8'h00;
      bus1.a_req_valid = 1'b0; bus1.a_req_op = 4'd0; bus1.a_req_x = 8'h00; bus1.a_req_y = 8'h00;
      bus1.b_req_valid = 1'b0; bus1.b_req_op = 4'd0; bus1.b_req_x = 8'h00; bus1.b_req_y = 8'h00;
      bus1.rsp_ready   = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_rsp_valid(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (bus3.rsp_valid === 1'b1) seen = 1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk1(name, seen, 1'b1);
   endtask

   // One table vector: issue it, watch the select for LAT cycles, then check the response.
   task automatic apply_stimulus(input vec_t v, input int idx);
      bit got;
      @(negedge clk);
      bus3.rsp_ready = 1'b1;
      if (v.id) begin
         bus3.b_req_valid = 1'b1; bus3.b_req_op = v.op; bus3.b_req_x = v.x; bus3.b_req_y = v.y;
      end else begin
         bus3.a_req_valid = 1'b1; bus3.a_req_op = v.op; bus3.a_req_x = v.x; bus3.a_req_y = v.y;
      end
      #1;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         if ((v.id ? bus3.b_req_ready : bus3.a_req_ready) === 1'b1) got = 1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk1($sformatf("vec%0d_grant", idx), got, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus3.a_req_valid = 1'b0;
      bus3.b_req_valid = 1'b0;
      #1;
      if (!v.exp_err) begin
         for (int k = 1; k <= LAT; k++) begin
            chk4($sformatf("vec%0d_sel_c%0d", idx, k), bus3.alu_sel, v.exp_sel);
            chk1($sformatf("vec%0d_early_valid_c%0d", idx, k), bus3.rsp_valid, 1'b0);
            if (k < LAT) begin
               @(negedge clk);
               #1;
            end
         end
         @(negedge clk);
         #1;
      end
      chk1($sformatf("vec%0d_rsp_valid", idx), bus3.rsp_valid, 1'b1);
      chk8($sformatf("vec%0d_rsp_data", idx), bus3.rsp_data, v.exp_data);
      chk1($sformatf("vec%0d_rsp_id", idx), bus3.rsp_id, v.id);
      chk1($sformatf("vec%0d_rsp_err", idx), bus3.rsp_err, v.exp_err);
      chk4($sformatf("vec%0d_sel_after", idx), bus3.alu_sel, 4'b0000);
      chk8($sformatf("vec%0d_alu_x", idx), bus3.alu_x, v.exp_x);
      @(negedge clk);
      #1;
      chk1($sformatf("vec%0d_idle", idx), bus3.busy, 1'b0);
   endtask

   // Randomized traffic against a transaction-level model of arbitration and latency.
   task automatic check_output(input int cycles);
      bit         m_busy, m_id, m_legal, m_last;
      int         m_age;
      logic [3:0] m_sel;
      logic [7:0] m_data;
      logic       av, bv, exp_ar, exp_br, exp_rv, rsp_fire;
      logic [3:0] aop, bop, op, exp_sel;
      logic [7:0] ax, ay, bx, by;
      m_busy = 0; m_id = 0; m_legal = 0; m_last = 1; m_age = 0;
      m_sel = 4'b0; m_data = 8'h00;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         av  = ($urandom_range(0, 1) == 1);
         bv  = ($urandom_range(0, 1) == 1);
         aop = 4'($urandom_range(0, 12));
         bop = 4'($urandom_range(0, 12));
         ax  = 8'($urandom); ay = 8'($urandom);
         bx  = 8'($urandom); by = 8'($urandom);
         bus3.a_req_valid = av; bus3.a_req_op = aop; bus3.a_req_x = ax; bus3.a_req_y = ay;
         bus3.b_req_valid = bv; bus3.b_req_op = bop; bus3.b_req_x = bx; bus3.b_req_y = by;
         bus3.rsp_ready   = ($urandom_range(0, 3) != 0);
         #1;
         exp_ar  = !m_busy && av && (!bv || m_last);
         exp_br  = !m_busy && bv && (!av || !m_last);
         exp_rv  = m_busy && (m_age >= (m_legal ? LAT + 1 : 1));
         exp_sel = (m_busy && m_legal && m_age <= LAT) ? m_sel : 4'b0000;
         chk1("rnd_a_ready", bus3.a_req_ready, exp_ar);
         chk1("rnd_b_ready", bus3.b_req_ready, exp_br);
         chk1("rnd_rsp_valid", bus3.rsp_valid, exp_rv);
         chk1("rnd_busy", bus3.busy, m_busy);
         chk4("rnd_alu_sel", bus3.alu_sel, exp_sel);
         if (exp_rv) begin
            chk8("rnd_rsp_data", bus3.rsp_data, m_data);
            chk1("rnd_rsp_id", bus3.rsp_id, m_id);
            chk1("rnd_rsp_err", bus3.rsp_err, !m_legal);
         end
         rsp_fire = exp_rv && bus3.rsp_ready;
         @(posedge clk);
         if (m_busy) m_age++;
         if (rsp_fire) m_busy = 0;
         if (exp_ar || exp_br) begin
            m_busy  = 1;
            m_age   = 1;
            m_id    = exp_br;
            m_last  = exp_br;
            op      = exp_br ? bop : aop;
            m_legal = (op <= 4'd10);
            m_sel   = m_legal ? sel_map[op] : 4'b0000;
            m_data  = m_legal ? alu_fn(m_sel, exp_br ? bx : ax, exp_br ? by : ay) : 8'h00;
         end
      end
      @(negedge clk);
      bus3.a_req_valid = 1'b0;
      bus3.b_req_valid = 1'b0;
      bus3.rsp_ready   = 1'b1;
      repeat (LAT + 3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] ax, ay, bx, by, exp_d;
      logic [1:0] grants;
      bit         got, saw_valid;

      sel_map = '{4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1001, 4'b1010,
                  4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

      //          id    op     x      y      sel      data   err   alu_x
      vecs[0]  = '{1'b0, 4'd2,  8'h12, 8'h34, 4'b0011, 8'h46, 1'b0, 8'h12};
      vecs[1]  = '{1'b0, 4'd0,  8'h5A, 8'h0F, 4'b0000, 8'h0A, 1'b0, 8'h5A};
      vecs[2]  = '{1'b1, 4'd1,  8'h5A, 8'h0F, 4'b0001, 8'h5F, 1'b0, 8'h5A};
      vecs[3]  = '{1'b0, 4'd2,  8'h5A, 8'h0F, 4'b0011, 8'h69, 1'b0, 8'h5A};
      vecs[4]  = '{1'b1, 4'd3,  8'h5A, 8'h0F, 4'b1000, 8'h4B, 1'b0, 8'h5A};
      vecs[5]  = '{1'b0, 4'd4,  8'h5A, 8'h0F, 4'b1001, 8'h55, 1'b0, 8'h5A};
      vecs[6]  = '{1'b1, 4'd5,  8'h5A, 8'h0F, 4'b1010, 8'hA5, 1'b0, 8'h5A};
      vecs[7]  = '{1'b0, 4'd6,  8'h5A, 8'h0F, 4'b1011, 8'hB4, 1'b0, 8'h5A};
      vecs[8]  = '{1'b1, 4'd7,  8'h5A, 8'h0F, 4'b1100, 8'h2D, 1'b0, 8'h5A};
      vecs[9]  = '{1'b0, 4'd8,  8'h5A, 8'h0F, 4'b1101, 8'hB5, 1'b0, 8'h5A};
      vecs[10] = '{1'b1, 4'd9,  8'h5A, 8'h0F, 4'b1110, 8'h5B, 1'b0, 8'h5A};
      vecs[11] = '{1'b0, 4'd10, 8'h5A, 8'h0F, 4'b1111, 8'hAF, 1'b0, 8'h5A};
      vecs[12] = '{1'b0, 4'd12, 8'h77, 8'h88, 4'b0000, 8'h00, 1'b1, 8'h5A};
      vecs[13] = '{1'b1, 4'd11, 8'h01, 8'h02, 4'b0000, 8'h00, 1'b1, 8'h5A};
      vecs[14] = '{1'b1, 4'd15, 8'hFF, 8'hFF, 4'b0000, 8'h00, 1'b1, 8'h5A};

      idle_inputs();
      bus3.rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_a_ready", bus3.a_req_ready, 1'b0);
      chk1("rst_b_ready", bus3.b_req_ready, 1'b0);
      chk1("rst_rsp_valid", bus3.rsp_valid, 1'b0);
      chk8("rst_rsp_data", bus3.rsp_data, 8'h00);
      chk1("rst_rsp_id", bus3.rsp_id, 1'b0);
      chk1("rst_rsp_err", bus3.rsp_err, 1'b0);
      chk8("rst_alu_x", bus3.alu_x, 8'h00);
      chk8("rst_alu_y", bus3.alu_y, 8'h00);
      chk4("rst_alu_sel", bus3.alu_sel, 4'b0000);
      chk1("rst_busy", bus3.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] single-cycle latency instance");
      @(negedge clk);
      bus1.a_req_valid = 1'b1; bus1.a_req_op = 4'd2; bus1.a_req_x = 8'h12; bus1.a_req_y = 8'h34;
      #1;
      chk1("lat1_a_ready", bus1.a_req_ready, 1'b1);
      chk1("lat1_b_ready", bus1.b_req_ready, 1'b0);
      @(negedge clk);
      bus1.a_req_valid = 1'b0;
      #1;
      chk4("lat1_sel_n1", bus1.alu_sel, 4'b0011);
      chk8("lat1_alu_x", bus1.alu_x, 8'h12);
      chk8("lat1_alu_y", bus1.alu_y, 8'h34);
      chk1("lat1_valid_n1", bus1.rsp_valid, 1'b0);
      chk1("lat1_busy_n1", bus1.busy, 1'b1);
      @(negedge clk);
      #1;
      chk1("lat1_valid_n2", bus1.rsp_valid, 1'b1);
      chk8("lat1_data", bus1.rsp_data, 8'h46);
      chk1("lat1_id", bus1.rsp_id, 1'b0);
      chk1("lat1_err", bus1.rsp_err, 1'b0);
      chk4("lat1_sel_n2", bus1.alu_sel, 4'b0000);
      @(negedge clk);
      #1;
      chk1("lat1_valid_n3", bus1.rsp_valid, 1'b0);
      chk1("lat1_busy_n3", bus1.busy, 1'b0);

      $display("[TB] vector table");
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(vecs[i], i);
      end

      $display("[TB] response backpressure");
      @(negedge clk);
      bus3.rsp_ready = 1'b0;
      bus3.a_req_valid = 1'b1; bus3.a_req_op = 4'd4; bus3.a_req_x = 8'h33; bus3.a_req_y = 8'h0F;
      #1;
      chk1("bp_grant", bus3.a_req_ready, 1'b1);
      @(negedge clk);
      bus3.b_req_valid = 1'b1; bus3.b_req_op = 4'd1; bus3.b_req_x = 8'hAA; bus3.b_req_y = 8'h55;
      bus3.a_req_x = 8'hCC;
      #1;
      wait_rsp_valid("bp_rsp_seen");
      for (int k = 0; k < 5; k++) begin
         chk1($sformatf("bp_valid_%0d", k), bus3.rsp_valid, 1'b1);
         chk8($sformatf("bp_data_%0d", k), bus3.rsp_data, 8'h3C);
         chk1($sformatf("bp_id_%0d", k), bus3.rsp_id, 1'b0);
         chk1($sformatf("bp_err_%0d", k), bus3.rsp_err, 1'b0);
         chk1($sformatf("bp_a_ready_%0d", k), bus3.a_req_ready, 1'b0);
         chk1($sformatf("bp_b_ready_%0d", k), bus3.b_req_ready, 1'b0);
         @(negedge clk);
         #1;
      end
      bus3.a_req_valid = 1'b0;
      bus3.b_req_valid = 1'b0;
      bus3.rsp_ready = 1'b1;
      #1;
      chk1("bp_valid_release", bus3.rsp_valid, 1'b1);
      @(negedge clk);
      #1;
      chk1("bp_idle_after", bus3.busy, 1'b0);
      chk1("bp_valid_after", bus3.rsp_valid, 1'b0);

      $display("[TB] round-robin arbitration");
      do_reset();
      bus3.rsp_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         ax = 8'($urandom); ay = 8'($urandom); bx = 8'($urandom); by = 8'($urandom);
         bus3.a_req_valid = (i < 8); bus3.a_req_op = 4'd2; bus3.a_req_x = ax; bus3.a_req_y = ay;
         bus3.b_req_valid = 1'b1;    bus3.b_req_op = 4'd4; bus3.b_req_x = bx; bus3.b_req_y = by;
         #1;
         got = 0;
         for (int w = 0; w < 8 && !got; w++) begin
            if ((bus3.a_req_ready | bus3.b_req_ready) === 1'b1) got = 1;
            else begin
               @(negedge clk);
               #1;
            end
         end
         chk1($sformatf("rr_grant_seen_%0d", i), got, 1'b1);
         grants = {bus3.a_req_ready, bus3.b_req_ready};
         if (i < 8) chk4($sformatf("rr_grant_%0d", i), {2'b00, grants}, (i % 2 == 0) ? 4'b0010 : 4'b0001);
         else       chk4($sformatf("rr_bonly_grant_%0d", i), {2'b00, grants}, 4'b0001);
         exp_d = (i < 8 && i % 2 == 0) ? alu_fn(sel_map[2], ax, ay) : alu_fn(sel_map[4], bx, by);
         @(negedge clk);
         bus3.a_req_valid = 1'b0;
         bus3.b_req_valid = 1'b0;
         #1;
         wait_rsp_valid($sformatf("rr_rsp_seen_%0d", i));
         chk1($sformatf("rr_rsp_id_%0d", i), bus3.rsp_id, (i < 8) ? 1'((i % 2)) : 1'b1);
         chk8($sformatf("rr_rsp_data_%0d", i), bus3.rsp_data, exp_d);
      end
      @(negedge clk);

      $display("[TB] reset during execution");
      @(negedge clk);
      bus3.a_req_valid = 1'b1; bus3.a_req_op = 4'd2; bus3.a_req_x = 8'h21; bus3.a_req_y = 8'h43;
      @(negedge clk);
      bus3.a_req_valid = 1'b0;
      #1;
      chk1("rst_exec_busy", bus3.busy, 1'b1);
      chk4("rst_exec_sel", bus3.alu_sel, 4'b0011);
      rst_n = 1'b0;
      #1;
      chk4("rst_exec_sel_clr", bus3.alu_sel, 4'b0000);
      chk8("rst_exec_x_clr", bus3.alu_x, 8'h00);
      chk8("rst_exec_y_clr", bus3.alu_y, 8'h00);
      chk1("rst_exec_busy_clr", bus3.busy, 1'b0);
      chk1("rst_exec_valid_clr", bus3.rsp_valid, 1'b0);
      chk8("rst_exec_data_clr", bus3.rsp_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         if (bus3.rsp_valid !== 1'b0 || bus3.busy !== 1'b0) saw_valid = 1;
      end
      chk1("rst_exec_no_rsp", saw_valid, 1'b0);

      $display("[TB] randomized traffic");
      check_output(600);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
